shift_issue_stage: RTL and testbench
====================================

SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
REQ-001 Parameter: RW, 3, destination register index width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  upstream instruction and operands valid.
REQ-006 in_ready  out  1  stage can accept this cycle.
REQ-007 instr  in  16  instruction word.
REQ-008 rs_data  in  16  value to be shifted.
REQ-009 rt_data  in  16  register count source; only bits [3:0] are used.
REQ-010 flush  in  1  discard all held entries.
REQ-011 out_valid  out  1  shifter operands valid.
REQ-012 out_ready  in  1  downstream consumes this cycle.
REQ-013 sh_in  out  16  data to shifter.
REQ-014 sh_cnt  out  4  shift count to shifter.
REQ-015 sh_op  out  2  shifter op: 00 rotate-left, 01 shift-left-logical, 10 rotate-right, 11 shift-right-logical.
REQ-016 wr_reg  out  RW  destination register.
REQ-017 illegal  out  1  one-cycle pulse when a non-shift instruction is consumed.

Function
REQ-018 Register form: when instr[15:11]=11010, the stage SHALL set sh_op=instr[1:0], sh_cnt=rt_data[3:0], and wr_reg=instr[4:2].
REQ-019 Accept rule: a transfer occurs when in_valid&&in_ready, and a delivery occurs when out_valid&&out_ready.
REQ-020 Storage: the stage SHALL be a two-entry skid buffer with states EMPTY, ONE, and FULL.
REQ-021 Ready: in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; in_ready SHALL depend only on registered state and never combinationally on out_ready.
REQ-022 Transitions: EMPTY goes to ONE on accept. ONE goes to FULL on accept without delivery, to EMPTY on delivery without accept, and stays in ONE on simultaneous accept and delivery. FULL goes to ONE on delivery.
REQ-023 Latency: an accepted shift instruction SHALL appear on the outputs the next cycle; minimum latency is 1, and throughput is 1 per cycle while out_ready=1.
REQ-024 Ordering: entries SHALL be delivered in acceptance order, with the head entry driving the outputs.
REQ-025 Hold: while out_valid=1 and out_ready=0, all outputs SHALL stay stable.
REQ-026 Illegal: an accepted non-shift instruction SHALL NOT be stored, SHALL pulse illegal the following cycle, and SHALL leave the state unchanged.
REQ-027 Flush: flush SHALL set the state to EMPTY next cycle and has priority over an accept or delivery in the same cycle; no illegal pulse is raised for an instruction presented during flush.
REQ-028 Idle outputs: when out_valid=0, sh_in, sh_cnt, sh_op, and wr_reg SHALL be 0.

Reset
REQ-029 On rst, the state SHALL be EMPTY and out_valid=0, illegal=0, in_ready=1, and all data outputs=0; rst has priority over flush.
REQ-030 A reset mid-operation SHALL discard held entries without delivering them.

Configuration
REQ-031 Macro SHIFT_IMM_EN: when defined, opcodes 101xx SHALL decode as immediate shifts with sh_op=instr[12:11], sh_cnt=instr[3:0], and wr_reg=instr[7:5]; when undefined, those opcodes SHALL be treated as illegal.

Structure
REQ-032 A shared package SHALL hold the sh_op encodings, the opcode constants 11010 and 101xx, and the skid state enum.
REQ-033 One sub-module, shift_decode, SHALL be purely combinational: instr, rs_data, and rt_data in; a shift/illegal flag, op, cnt, reg, and data out.

Verification
REQ-034 Scenario 1: instr=0xD001 (rs=x0, rt=x0), rs_data=0x8001, rt_data=0x0004, out_ready=1 -> next cycle out_valid=1, sh_in=0x8001, sh_cnt=4, sh_op=01, wr_reg=0.
REQ-035 Scenario 2: three back-to-back accepts with out_ready=0 -> in_ready falls after the second accept, the third is held upstream, and after out_ready=1 delivery order is 1, 2, 3.
REQ-036 Scenario 3: FULL state, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no delivery.
REQ-037 Scenario 4: instr=0x0800, in_valid=1 -> illegal=1 for one cycle and out_valid stays 0.
REQ-038 Scenario 5: with SHIFT_IMM_EN defined, instr=0xB8EF -> sh_op=11, sh_cnt=15, wr_reg=7; without the macro -> illegal=1.
REQ-039 Scenario 6: rst asserted in state ONE with out_ready=0 -> next cycle out_valid=0 and all outputs=0.

Source files
------------

// File: rtl/shift_issue_stage_pkg.sv
// Shared types and constants for the shift issue stage: shifter op encodings,
// shift opcodes, the skid buffer state and the buffered payload.
package shift_issue_stage_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 4;
  localparam int unsigned OPW = 2;

  typedef enum logic [OPW-1:0] {
    SH_ROL = 2'b00,
    SH_SLL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } sh_op_e;

  localparam logic [4:0] OPC_SHIFT_REG = 5'b11010;
  localparam logic [4:0] OPC_SHIFT_IMM = 5'b101??;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    sh_op_e        op;
  } shift_payload_t;

  // Wildcard match of the immediate-shift opcode group.
  function automatic logic is_imm_opc(input logic [4:0] opc);
    return opc ==? OPC_SHIFT_IMM;
  endfunction

endpackage

// File: rtl/shift_decode.sv
// Combinational shift-instruction decode. Immediate shifts (opcodes 101xx)
// are recognised only when SHIFT_IMM_EN is defined; otherwise they are illegal.
module shift_decode
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned RW = 3
) (
  input  logic [15:0]   instr,
  input  logic [15:0]   rs_data,
  input  logic [15:0]   rt_data,
  output logic          is_shift,
  output logic          illegal,
  output sh_op_e        op,
  output logic [CW-1:0] cnt,
  output logic [RW-1:0] rd,
  output logic [DW-1:0] data
);

  logic unused_bits;
  assign unused_bits = ^{instr[10:5], rt_data[15:4]};

  always_comb begin
    is_shift = 1'b0;
    op       = SH_ROL;
    cnt      = '0;
    rd       = '0;
    data     = rs_data;
    if (instr[15:11] == OPC_SHIFT_REG) begin
      is_shift = 1'b1;
      op       = sh_op_e'(instr[1:0]);
      cnt      = rt_data[3:0];
      rd       = RW'(instr[4:2]);
    end
`ifdef SHIFT_IMM_EN
    else if (is_imm_opc(instr[15:11])) begin
      is_shift = 1'b1;
      op       = sh_op_e'(instr[12:11]);
      cnt      = instr[3:0];
      rd       = RW'(instr[7:5]);
    end
`endif
  end

  assign illegal = ~is_shift;

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes shift instructions into a two-entry skid buffer
// feeding the shifter. Optional immediate-shift decode via SHIFT_IMM_EN.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  input  logic [15:0]   rs_data,
  input  logic [15:0]   rt_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   sh_in,
  output logic [3:0]    sh_cnt,
  output logic [1:0]    sh_op,
  output logic [RW-1:0] wr_reg,
  output logic          illegal
);

  logic          dec_shift;
  logic          dec_illegal;
  sh_op_e        dec_op;
  logic [CW-1:0] dec_cnt;
  logic [RW-1:0] dec_rd;
  logic [DW-1:0] dec_data;

  shift_decode #(.RW(RW)) u_decode (
    .instr    (instr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .is_shift (dec_shift),
    .illegal  (dec_illegal),
    .op       (dec_op),
    .cnt      (dec_cnt),
    .rd       (dec_rd),
    .data     (dec_data)
  );

  skid_state_e    state_q, state_d;
  shift_payload_t head_q, head_d, tail_q, tail_d;
  logic [RW-1:0]  head_rd_q, head_rd_d, tail_rd_q, tail_rd_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           illegal_q, illegal_d;

  logic           take, acc, dlv;
  shift_payload_t new_entry;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    head_rd_d = head_rd_q;
    tail_rd_d = tail_rd_q;

    take      = in_valid && in_ready_q && !flush;
    acc       = take && dec_shift;
    illegal_d = take && dec_illegal;
    dlv       = out_valid_q && out_ready;
    new_entry = '{data: dec_data, cnt: dec_cnt, op: dec_op};

    if (flush) begin
      state_d   = ST_EMPTY;
      head_d    = '0;
      tail_d    = '0;
      head_rd_d = '0;
      tail_rd_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d   = ST_ONE;
            head_d    = new_entry;
            head_rd_d = dec_rd;
          end
        end
        ST_ONE: begin
          if (acc && dlv) begin
            head_d    = new_entry;
            head_rd_d = dec_rd;
          end else if (acc) begin
            state_d   = ST_FULL;
            tail_d    = new_entry;
            tail_rd_d = dec_rd;
          end else if (dlv) begin
            state_d   = ST_EMPTY;
            head_d    = '0;
            head_rd_d = '0;
          end
        end
        ST_FULL: begin
          // Ready is low here, so only a delivery can move the buffer.
          if (dlv) begin
            state_d   = ST_ONE;
            head_d    = tail_q;
            head_rd_d = tail_rd_q;
            tail_d    = '0;
            tail_rd_d = '0;
          end
        end
        default: begin
          state_d   = ST_EMPTY;
          head_d    = '0;
          tail_d    = '0;
          head_rd_d = '0;
          tail_rd_d = '0;
        end
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      head_rd_q   <= '0;
      tail_rd_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_rd_q   <= head_rd_d;
      tail_rd_q   <= tail_rd_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sh_in     = head_q.data;
  assign sh_cnt    = head_q.cnt;
  assign sh_op     = head_q.op;
  assign wr_reg    = head_rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage; scenario 5 expectations follow SHIFT_IMM_EN.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sh_in;
  logic [3:0]  sh_cnt;
  logic [1:0]  sh_op;
  logic [2:0]  wr_reg;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  shift_issue_stage #(.RW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sh_in     (sh_in),
    .sh_cnt    (sh_cnt),
    .sh_op     (sh_op),
    .wr_reg    (wr_reg),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                         input logic [3:0] c, input logic [1:0] op, input logic [2:0] rd);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sh_in"},     32'(sh_in),     32'(d));
    chk({tag, ".sh_cnt"},    32'(sh_cnt),    32'(c));
    chk({tag, ".sh_op"},     32'(sh_op),     32'(op));
    chk({tag, ".wr_reg"},    32'(wr_reg),    32'(rd));
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] rs,
                       input logic [15:0] rt);
    in_valid = v;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.illegal",  32'(illegal),  32'd0);
    chk_out("rst", 1'b0, 16'h0, 4'h0, 2'b00, 3'd0);
    rst = 1'b0;

    // Scenario 1: register-form SLL, one-cycle latency, then drains
    out_ready = 1'b1;
    drive(1'b1, 16'hD001, 16'h8001, 16'h0004);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk_out("s1", 1'b1, 16'h8001, 4'd4, 2'b01, 3'd0);
    tick();
    chk_out("s1.drain", 1'b0, 16'h0, 4'd0, 2'b00, 3'd0);

    // Scenario 2: three accepts with a stalled consumer, in-order drain
    out_ready = 1'b0;
    drive(1'b1, 16'hD004, 16'h1111, 16'hFFF1);
    tick();
    chk("s2.a.in_ready", 32'(in_ready), 32'd1);
    chk_out("s2.a", 1'b1, 16'h1111, 4'd1, 2'b00, 3'd1);
    drive(1'b1, 16'hD00A, 16'h2222, 16'h0002);
    tick();
    chk("s2.b.in_ready", 32'(in_ready), 32'd0);
    chk_out("s2.b.hold", 1'b1, 16'h1111, 4'd1, 2'b00, 3'd1);
    drive(1'b1, 16'hD00F, 16'h3333, 16'h0003);
    tick();
    chk("s2.c.in_ready", 32'(in_ready), 32'd0);
    chk_out("s2.c.hold", 1'b1, 16'h1111, 4'd1, 2'b00, 3'd1);
    out_ready = 1'b1;
    tick();
    chk("s2.d2.in_ready", 32'(in_ready), 32'd1);
    chk_out("s2.d2", 1'b1, 16'h2222, 4'd2, 2'b10, 3'd2);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk_out("s2.d3", 1'b1, 16'h3333, 4'd3, 2'b11, 3'd3);
    tick();
    chk_out("s2.empty", 1'b0, 16'h0, 4'd0, 2'b00, 3'd0);

    // Scenario 3: flush from FULL wins over a presented instruction
    out_ready = 1'b0;
    drive(1'b1, 16'hD004, 16'h1111, 16'h0001);
    tick();
    drive(1'b1, 16'hD00A, 16'h2222, 16'h0002);
    tick();
    chk("s3.full.in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 16'hD00F, 16'h3333, 16'h0003);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk("s3.in_ready", 32'(in_ready), 32'd1);
    chk_out("s3.flushed", 1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
    tick();
    chk("s3.after.out_valid", 32'(out_valid), 32'd0);

    // Non-shift instruction under flush raises no illegal pulse
    drive(1'b1, 16'h0800, 16'h0, 16'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk("flush.illegal", 32'(illegal), 32'd0);

    // Scenario 4: illegal instruction pulses for one cycle, not stored
    drive(1'b1, 16'h0800, 16'h5555, 16'h0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk("s4.illegal", 32'(illegal), 32'd1);
    chk("s4.out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("s4.illegal.drop", 32'(illegal), 32'd0);

    // Illegal in ONE keeps the state: the next legal accept fills to FULL
    out_ready = 1'b0;
    drive(1'b1, 16'hD004, 16'h1111, 16'h0001);
    tick();
    drive(1'b1, 16'h0800, 16'h9999, 16'h0);
    tick();
    chk("ill1.illegal", 32'(illegal), 32'd1);
    chk("ill1.in_ready", 32'(in_ready), 32'd1);
    chk_out("ill1.head", 1'b1, 16'h1111, 4'd1, 2'b00, 3'd1);
    drive(1'b0, 16'h0, 16'h0, 16'h0);

    // Scenario 6: reset in ONE with a stalled consumer drops the entry
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6.in_ready", 32'(in_ready), 32'd1);
    chk("s6.illegal", 32'(illegal), 32'd0);
    chk_out("s6", 1'b0, 16'h0, 4'd0, 2'b00, 3'd0);

    // Scenario 5: immediate-form opcode depends on SHIFT_IMM_EN
    out_ready = 1'b0;
    drive(1'b1, 16'hB8EF, 16'hABCD, 16'h0002);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
`ifdef SHIFT_IMM_EN
    chk("s5.illegal", 32'(illegal), 32'd0);
    chk_out("s5", 1'b1, 16'hABCD, 4'd15, 2'b11, 3'd7);
`else
    chk("s5.illegal", 32'(illegal), 32'd1);
    chk_out("s5", 1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk("s5.drain.out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
